// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: arbitrates up to four writeback requesters onto a single
// register-file write port. Round-robin priority with a starvation override,
// a flush that suppresses grants, and a one-cycle registered write output.
module rf_wb_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*5-1:0]  req_rd,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  flush,
  output logic                  wen,
  output logic [4:0]            rd,
  output logic [31:0]           w_data,
  output logic [1:0]            grant_id
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  // Unpacked views of the flattened request buses
  logic [4:0]  rd_arr   [NUM_REQ];
  logic [31:0] data_arr [NUM_REQ];

  // Per-requester starvation state
  logic [3:0]  wait_q   [NUM_REQ];
  logic [3:0]  wait_d   [NUM_REQ];
  logic [NUM_REQ-1:0] starving;

  // Arbitration result for the current cycle
  logic        grant_found;
  logic [1:0]  grant_idx;

  // Round-robin pointer: names the highest-priority requester
  logic [1:0]  rr_ptr_q;
  logic [1:0]  rr_ptr_d;

  // Registered write port
  logic        wen_q;
  logic        wen_d;
  logic [4:0]  rd_q;
  logic [4:0]  rd_d;
  logic [31:0] w_data_q;
  logic [31:0] w_data_d;
  logic [1:0]  grant_id_q;
  logic [1:0]  grant_id_d;

  // (base + k) mod NUM_REQ, with base < NUM_REQ and k < NUM_REQ + 1
  function automatic logic [1:0] wrap_add(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end
    return s[1:0];
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign rd_arr[gi]   = req_rd[5*gi +: 5];
      assign data_arr[gi] = req_data[32*gi +: 32];
      assign starving[gi] = req_valid[gi] && (wait_q[gi] == MAX_W);

      // A requester is ready only in the cycle it wins arbitration
      assign req_ready[gi] = grant_found && (grant_idx == 2'(gi));

      // Wait counter: count denied cycles, saturate, clear on grant/idle/flush
      always_comb begin
        wait_d[gi] = wait_q[gi];
        if (flush || !req_valid[gi] || req_ready[gi]) begin
          wait_d[gi] = 4'd0;
        end else if (wait_q[gi] != MAX_W) begin
          wait_d[gi] = wait_q[gi] + 4'd1;
        end
      end

      // Wait counter register
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wait_q[gi] <= 4'd0;
        end else begin
          wait_q[gi] <= wait_d[gi];
        end
      end
    end
  endgenerate

  // Pick the winner: lowest starving requester first, else round-robin from rr_ptr.
  // Nothing is granted during flush or while reset is held.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    if (!flush && !rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_found && starving[i]) begin
          grant_found = 1'b1;
          grant_idx   = 2'(i);
        end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant_found && req_valid[wrap_add(rr_ptr_q, k)]) begin
          grant_found = 1'b1;
          grant_idx   = wrap_add(rr_ptr_q, k);
        end
      end
    end
  end

  // Next pointer and next write-port contents from the arbitration result
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wen_d      = 1'b0;
    rd_d       = rd_q;
    w_data_d   = w_data_q;
    grant_id_d = grant_id_q;
    if (grant_found) begin
      rr_ptr_d   = wrap_add(grant_idx, 1);
      // x0 is hardwired to zero: accept the transfer but never write it
      wen_d      = (rd_arr[grant_idx] != 5'd0);
      rd_d       = rd_arr[grant_idx];
      w_data_d   = data_arr[grant_idx];
      grant_id_d = grant_idx;
    end
  end

  // Pointer and write-port registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= 2'd0;
      wen_q      <= 1'b0;
      rd_q       <= 5'd0;
      w_data_q   <= 32'd0;
      grant_id_q <= 2'd0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wen_q      <= wen_d;
      rd_q       <= rd_d;
      w_data_q   <= w_data_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign wen      = wen_q;
  assign rd       = rd_q;
  assign w_data   = w_data_q;
  assign grant_id = grant_id_q;

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, SHALL set the number of writeback requesters (legal range 2..4).
REQ-002 Parameter MAX_WAIT, default 4, SHALL set the wait-cycle threshold that raises starvation priority (legal range 1..15).
REQ-003 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 req_valid  in  NUM_REQ  SHALL be the per-requester writeback request.
REQ-006 req_rd  in  NUM_REQ*5  SHALL be the per-requester destination register index; slice i is bits [5i+4:5i].
REQ-007 req_data  in  NUM_REQ*32  SHALL be the per-requester write data; slice i is bits [32i+31:32i].
REQ-008 req_ready  out  NUM_REQ  SHALL be the grant/accept indication, combinational, at most one bit set.
REQ-009 flush  in  1  SHALL be the pipeline flush; it suppresses all grants that cycle.
REQ-010 wen  out  1  SHALL be the registered register-file write enable.
REQ-011 rd  out  5  SHALL be the registered register-file write index.
REQ-012 w_data  out  32  SHALL be the registered register-file write data.
REQ-013 grant_id  out  2  SHALL be the registered index of the requester whose write is on wen/rd/w_data.

Function
REQ-014 Handshake: a transfer from requester i SHALL occur in a cycle where req_valid[i] && req_ready[i]; requesters hold valid, rd and data stable until accepted.
REQ-015 At most one requester SHALL be granted per cycle; req_ready[i] SHALL never assert when req_valid[i]=0 or flush=1.
REQ-016 Latency: a write accepted in cycle N SHALL appear on wen/rd/w_data/grant_id in cycle N+1, for exactly one cycle unless another write is accepted in N+1.
REQ-017 If no transfer occurs in cycle N, wen SHALL be 0 in cycle N+1; rd, w_data and grant_id SHALL hold their previous values.
REQ-018 A transfer with rd=0 SHALL be accepted normally, but wen SHALL be 0 in the following cycle (x0 is never written).
REQ-019 Round-robin: a pointer rr_ptr (reset 0) SHALL name the highest-priority requester; priority descends rr_ptr, rr_ptr+1, ... mod NUM_REQ.
REQ-020 After a grant to requester i, rr_ptr SHALL become (i+1) mod NUM_REQ; with no grant, rr_ptr SHALL hold.
REQ-021 Per-requester wait counter wait_cnt[i] (4 bits) SHALL increment, saturating at MAX_WAIT, each cycle req_valid[i] && !req_ready[i] && !flush.
REQ-022 wait_cnt[i] SHALL clear to 0 on a grant to i, when req_valid[i]=0, or when flush=1.
REQ-023 Starvation override: if any wait_cnt[i]==MAX_WAIT with req_valid[i]=1, the lowest such i SHALL be granted, ignoring round-robin; rr_ptr SHALL still update per REQ-020.
REQ-024 Flush: in a cycle with flush=1, no grant SHALL occur, wen SHALL be 0 in the next cycle, and rr_ptr SHALL hold; a write already registered on the outputs in the flush cycle SHALL still complete.
REQ-025 Simultaneous requests with equal priority class SHALL resolve only through REQ-019/REQ-023; arbitration is deterministic for identical history.
REQ-026 Two writes to the same rd in consecutive cycles SHALL both be issued in grant order (no merging or reordering).

Reset
REQ-027 While RST=1, asynchronously: wen=0, rd=0, w_data=0, grant_id=0, rr_ptr=0, all wait_cnt=0, all req_ready=0.
REQ-028 Reset asserted mid-operation SHALL discard any accepted but not yet issued write; the first grant after deassertion SHALL follow REQ-019 from rr_ptr=0.

Verification
REQ-029 Single request: valid[1]=1, rd=5, data=0xDEADBEEF in cycle 2 -> ready[1]=1 in cycle 2; wen=1, rd=5, w_data=0xDEADBEEF, grant_id=1 in cycle 3; wen=0 in cycle 4.
REQ-030 All three valid continuously from reset -> grants in order 0,1,2,0,1,2 on consecutive cycles; wen=1 every cycle from the 2nd cycle on.
REQ-031 x0 write: valid[2]=1, rd=0 -> ready[2]=1, next-cycle wen=0, grant_id=2.
REQ-032 Starvation (MAX_WAIT=2): requester 2 valid and denied for 2 cycles -> granted in the 3rd cycle even when rr_ptr=0 and valid[0]=1.
REQ-033 Flush: all valid with flush=1 for one cycle -> ready=000 that cycle, wen=0 next cycle, wait counters 0, grant order resumes from held rr_ptr.
REQ-034 Reset mid-stream: RST pulsed asynchronously between edges while wen=1 -> wen=0 immediately; first grant after release goes to requester 0.
